cmd_frame_parser: RTL

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

---
 rtl/drone_link_pkg.sv | 14 +
 rtl/byte_strobe.sv | 22 ++
 rtl/cmd_frame_parser.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/drone_link_pkg.sv
// drone_link_pkg: shared constants and parser state encoding for the drone command link.
package drone_link_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEF      = 8'hA5;
    localparam int unsigned NUM_CH_DEF         = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 12000;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_PAYLOAD = 2'd1;
    localparam logic [STATE_W-1:0] ST_CHECK   = 2'd2;

endpackage

// File: rtl/byte_strobe.sv
// byte_strobe: one-cycle acceptance strobe on the rising edge of the upstream byte-valid level.
module byte_strobe (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic strobe_c_o
);

    logic level_q;

    // Previous level; cleared on reset so a level already high at release counts as a new edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign strobe_c_o = level_i & ~level_q;

endmodule

// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: parses SYNC + 2*NUM_CH payload bytes + 8-bit sum checksum into NUM_CH
// little-endian 16-bit channels. Define CMD_FRAME_TIMEOUT_EN to abort frames whose
// inter-byte gap reaches TIMEOUT_CYCLES.
module cmd_frame_parser
    import drone_link_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned NUM_CH         = NUM_CH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            data,
    input  logic                  data_rdy,
    output logic [16*NUM_CH-1:0]  ch,
    output logic                  frame_valid,
    output logic                  frame_err
);

    localparam int unsigned PAY_LEN = 2 * NUM_CH;
    localparam int unsigned PAY_W   = 8 * PAY_LEN;
    localparam int unsigned IDX_W   = (PAY_LEN > 1) ? $clog2(PAY_LEN) : 1;

    logic               accept_c;
    logic               timeout_c;
    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         sum_q, sum_d;
    logic [PAY_W-1:0]   shadow_q, shadow_d;
    logic [PAY_W-1:0]   ch_q, ch_d;
    logic               frame_valid_q, frame_valid_d;
    logic               frame_err_q, frame_err_d;

`ifdef CMD_FRAME_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_W-1:0] gap_q, gap_d;

    // An accepted byte always beats a timeout reached in the same cycle.
    assign timeout_c = !accept_c && (state_q != ST_IDLE) && (gap_q == GAP_W'(TIMEOUT_CYCLES));
`else
    // Frames wait indefinitely for bytes; TIMEOUT_CYCLES has no effect in this build.
    assign timeout_c = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    byte_strobe u_byte_strobe (
        .clk        (clk),
        .reset      (reset),
        .level_i    (data_rdy),
        .strobe_c_o (accept_c)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            sum_q         <= '0;
            shadow_q      <= '0;
            ch_q          <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
`ifdef CMD_FRAME_TIMEOUT_EN
            gap_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            shadow_q      <= shadow_d;
            ch_q          <= ch_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
`ifdef CMD_FRAME_TIMEOUT_EN
            gap_q         <= gap_d;
`endif
        end
    end

    // Next-state: collect payload into the shadow buffer, publish it to ch only on a good checksum.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        shadow_d      = shadow_q;
        ch_d          = ch_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
`ifdef CMD_FRAME_TIMEOUT_EN
        gap_d         = '0;
        if (!accept_c && state_q != ST_IDLE) begin
            gap_d = gap_q + GAP_W'(1);
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept_c && data == SYNC_BYTE) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            ST_PAYLOAD: begin
                if (accept_c) begin
                    for (int unsigned i = 0; i < PAY_LEN; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            shadow_d[8*i +: 8] = data;
                        end
                    end
                    sum_d = sum_q + data;
                    if (idx_q == IDX_W'(PAY_LEN - 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (accept_c) begin
                    if (data == sum_q) begin
                        ch_d          = shadow_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        frame_err_d   = 1'b1;
                    end
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        if (timeout_c) begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            frame_err_d = 1'b1;
        end
    end

    assign ch          = ch_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule
